oam_sprite_scan: RTL and testbench

- Mode-2 OAM scan stage for the PPU, directly upstream of the 10-slot sprite store.
- Walks all 40 OAM entries in 80 clock cycles and tests each entry's Y byte against the current LY.
- For each of the first 10 hits it issues one write strobe to the store carrying slot number, OAM index and row-within-sprite.
- Reports hit count and scan completion to the fetch/render control.

---
 rtl/oam_sprite_scan_if.sv | 21 ++
 rtl/oam_sprite_scan.sv | 134 +++++++++++++
 tb/tb_oam_sprite_scan.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/oam_sprite_scan_if.sv
// OAM read port and sprite-store write port of the mode-2 scanner.
// The master side is the scanner; the slave side is OAM plus sprite store.
interface oam_sprite_scan_if;
  logic [5:0] oam_addr;
  logic       oam_rd;
  logic [7:0] oam_y;
  logic       store_we;
  logic [3:0] store_slot;
  logic [5:0] store_idx;
  logic [3:0] store_line;

  modport master (
    output oam_addr, oam_rd, store_we, store_slot, store_idx, store_line,
    input  oam_y
  );

  modport slave (
    input  oam_addr, oam_rd, store_we, store_slot, store_idx, store_line,
    output oam_y
  );
endinterface

// File: rtl/oam_sprite_scan.sv
// Mode-2 OAM scan: reads each entry's Y byte in a READ/EVAL cycle pair,
// tests it against the latched line and forwards the first N_SLOTS hits
// to the sprite store. Scan timing is fixed at 2*N_OAM cycles regardless
// of how many hits occur.
module oam_sprite_scan #(
  parameter int N_OAM    = 40,
  parameter int N_SLOTS  = 10,
  parameter int Y_OFFSET = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               scan_start_i,
  input  logic [7:0]         ly_i,
  input  logic               obj_tall_i,
  oam_sprite_scan_if.master  bus,
  output logic [3:0]         sprite_count_o,
  output logic               scan_busy_o,
  output logic               scan_done_o
);

  typedef enum logic [1:0] {IDLE, READ, EVAL, DONE} state_t;

  localparam logic [3:0] SLOTS_MAX  = 4'(N_SLOTS);
  localparam logic [5:0] LAST_ENTRY = 6'(N_OAM - 1);

  state_t     state_q, state_d;
  logic [5:0] entry_q, entry_d;
  logic [3:0] count_q, count_d;
  logic [7:0] ly_q,    ly_d;
  logic       tall_q,  tall_d;
  logic [3:0] slot_q,  slot_d;
  logic [5:0] idx_q,   idx_d;
  logic [3:0] line_q,  line_d;
  logic       we;
  logic [8:0] diff;
  logic       hit;

  // Row-in-range test: the 9-bit difference is negative when the sprite
  // starts below the line, and must be under the sprite height otherwise.
  function automatic logic row_hit(input logic [8:0] d, input logic tall);
    return !d[8] && (d < (tall ? 9'd16 : 9'd8));
  endfunction

  // 9-bit difference keeps ly + offset from wrapping for lines near 255.
  assign diff = {1'b0, ly_q} + 9'(Y_OFFSET) - {1'b0, bus.oam_y};
  assign hit  = row_hit(diff, tall_q);

  // State and datapath registers; reset clears latched line parameters too.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      entry_q <= '0;
      count_q <= '0;
      ly_q    <= '0;
      tall_q  <= 1'b0;
      slot_q  <= '0;
      idx_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      count_q <= count_d;
      ly_q    <= ly_d;
      tall_q  <= tall_d;
      slot_q  <= slot_d;
      idx_q   <= idx_d;
      line_q  <= line_d;
    end
  end

  // Next-state logic and strobe generation; scan_start overrides everything.
  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    count_d    = count_q;
    ly_d       = ly_q;
    tall_d     = tall_q;
    slot_d     = slot_q;
    idx_d      = idx_q;
    line_d     = line_q;
    we         = 1'b0;
    bus.oam_rd = 1'b0;

    case (state_q)
      READ: begin
        bus.oam_rd = 1'b1;
        state_d    = EVAL;
      end
      EVAL: begin
        if (hit && (count_q < SLOTS_MAX)) begin
          we      = 1'b1;
          slot_d  = count_q;
          idx_d   = entry_q;
          line_d  = diff[3:0];
          count_d = count_q + 4'd1;
        end
        if (entry_q == LAST_ENTRY) begin
          entry_d = '0;
          state_d = DONE;
        end else begin
          entry_d = entry_q + 6'd1;
          state_d = READ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = state_q;
    endcase

    // A restart discards the in-flight evaluation, including any strobe.
    if (scan_start_i) begin
      state_d = READ;
      entry_d = '0;
      count_d = '0;
      ly_d    = ly_i;
      tall_d  = obj_tall_i;
      we      = 1'b0;
      slot_d  = slot_q;
      idx_d   = idx_q;
      line_d  = line_q;
    end

    // Store fields show the new values during a strobe and hold otherwise.
    bus.store_we   = we;
    bus.store_slot = slot_d;
    bus.store_idx  = idx_d;
    bus.store_line = line_d;
  end

  assign bus.oam_addr   = entry_q;
  assign sprite_count_o = count_q;
  assign scan_busy_o    = (state_q == READ) || (state_q == EVAL);
  assign scan_done_o    = (state_q == DONE);

endmodule

// File: tb/tb_oam_sprite_scan.sv
// Bench for oam_sprite_scan: directed and randomized scans compared with a
// list-of-hits reference model computed straight from the Y/line rules.
module tb_oam_sprite_scan;

  logic       clk = 1'b0;
  logic       reset;
  logic       scan_start;
  logic [7:0] ly;
  logic       obj_tall;
  logic [3:0] sprite_count;
  logic       scan_busy;
  logic       scan_done;

  oam_sprite_scan_if bus ();

  oam_sprite_scan dut (
    .clk            (clk),
    .reset          (reset),
    .scan_start_i   (scan_start),
    .ly_i           (ly),
    .obj_tall_i     (obj_tall),
    .bus            (bus.master),
    .sprite_count_o (sprite_count),
    .scan_busy_o    (scan_busy),
    .scan_done_o    (scan_done)
  );

  always #5 clk = ~clk;

  // OAM: Y byte appears the cycle after the read request.
  logic [7:0] mem [40];
  always @(posedge clk) if (bus.oam_rd) bus.oam_y <= mem[bus.oam_addr];

  typedef struct { int slot; int idx; int line; } hit_t;
  hit_t exp_q[$];
  hit_t obs_q[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: first ten entries whose rows cover line l, in OAM order.
  function automatic void model(input int l, input bit tall);
    hit_t e;
    int   h;
    int   d;
    exp_q.delete();
    h = tall ? 16 : 8;
    for (int i = 0; i < 40; i++) begin
      d = l + 16 - int'(mem[i]);
      if (d >= 0 && d < h && exp_q.size() < 10) begin
        e.slot = exp_q.size();
        e.idx  = i;
        e.line = d;
        exp_q.push_back(e);
      end
    end
  endfunction

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 40; i++) mem[i] = v;
  endtask

  task automatic start(input int l, input bit tall);
    model(l, tall);
    @(negedge clk);
    scan_start = 1'b1;
    ly         = 8'(l);
    obj_tall   = tall;
    @(negedge clk);
    scan_start = 1'b0;
  endtask

  // Checks 81 cycles of a scan starting at the first READ, scrambling the
  // line inputs meanwhile, then compares the collected strobes.
  task automatic body();
    hit_t o;
    int   n;
    obs_q.delete();
    for (int k = 1; k <= 81; k++) begin
      if (k <= 80) begin
        chk("busy", 32'(scan_busy), 32'd1);
        chk("done_early", 32'(scan_done), 32'd0);
        chk("oam_rd", 32'(bus.oam_rd), 32'(k % 2));
        if (k % 2 == 1) chk("oam_addr", 32'(bus.oam_addr), 32'((k - 1) / 2));
        if (bus.store_we) begin
          o.slot = int'(bus.store_slot);
          o.idx  = int'(bus.store_idx);
          o.line = int'(bus.store_line);
          obs_q.push_back(o);
        end
      end else begin
        chk("done", 32'(scan_done), 32'd1);
        chk("busy_at_done", 32'(scan_busy), 32'd0);
        chk("rd_at_done", 32'(bus.oam_rd), 32'd0);
        chk("we_at_done", 32'(bus.store_we), 32'd0);
      end
      ly       = 8'($urandom);
      obj_tall = 1'($urandom);
      @(negedge clk);
    end
    chk("done_pulse", 32'(scan_done), 32'd0);
    chk("idle_busy", 32'(scan_busy), 32'd0);
    chk("n_strobes", 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk("slot", 32'(obs_q[i].slot), 32'(exp_q[i].slot));
      chk("idx",  32'(obs_q[i].idx),  32'(exp_q[i].idx));
      chk("line", 32'(obs_q[i].line), 32'(exp_q[i].line));
    end
    chk("sprite_count", 32'(sprite_count), 32'(exp_q.size()));
    if (exp_q.size() > 0) begin
      chk("hold_slot", 32'(bus.store_slot), 32'(exp_q[exp_q.size()-1].slot));
      chk("hold_idx",  32'(bus.store_idx),  32'(exp_q[exp_q.size()-1].idx));
      chk("hold_line", 32'(bus.store_line), 32'(exp_q[exp_q.size()-1].line));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"},  32'(bus.oam_addr),   32'd0);
    chk({tag, "_rd"},    32'(bus.oam_rd),     32'd0);
    chk({tag, "_we"},    32'(bus.store_we),   32'd0);
    chk({tag, "_slot"},  32'(bus.store_slot), 32'd0);
    chk({tag, "_idx"},   32'(bus.store_idx),  32'd0);
    chk({tag, "_line"},  32'(bus.store_line), 32'd0);
    chk({tag, "_count"}, 32'(sprite_count),   32'd0);
    chk({tag, "_busy"},  32'(scan_busy),      32'd0);
    chk({tag, "_done"},  32'(scan_done),      32'd0);
  endtask

  initial begin
    int l;
    reset      = 1'b1;
    scan_start = 1'b0;
    ly         = 8'd0;
    obj_tall   = 1'b0;
    fill(8'd0);
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    chk_all_zero("idle");

    // Empty scan: no hits, done 81 cycles after the start pulse.
    fill(8'd0);
    start(0, 1'b0);
    body();

    // Two hits, entry 7 just past the bottom row.
    mem[5] = 8'd16; mem[6] = 8'd9; mem[7] = 8'd8;
    start(0, 1'b0);
    body();
    chk("dir_count2", 32'(sprite_count), 32'd2);
    if (obs_q.size() == 2) chk("dir_second_line", 32'(obs_q[1].line), 32'd7);

    // Tall sprite row 14, then the same with short sprites.
    fill(8'd0);
    mem[0] = 8'd12;
    start(10, 1'b1);
    body();
    if (obs_q.size() >= 1) chk("tall_line", 32'(obs_q[0].line), 32'd14);
    start(10, 1'b0);
    body();
    chk("short_count", 32'(sprite_count), 32'd0);

    // Saturation: every entry hits, only ten stored.
    fill(8'd16);
    start(0, 1'b0);
    body();
    chk("sat_count", 32'(sprite_count), 32'd10);

    // Bottom-of-screen edges and 9-bit overflow of ly + 16.
    fill(8'd0);
    mem[0] = 8'd176; mem[1] = 8'd159; mem[2] = 8'd144; mem[3] = 8'd143;
    start(143, 1'b1);
    body();
    fill(8'd0);
    mem[3] = 8'd255; mem[4] = 8'd250;
    start(250, 1'b1);
    body();

    // Restart after three hits; the aborted scan must not signal done.
    fill(8'd0);
    mem[0] = 8'd16; mem[1] = 8'd16; mem[2] = 8'd16;
    start(0, 1'b0);
    repeat (6) @(negedge clk);
    chk("pre_restart_count", 32'(sprite_count), 32'd3);
    scan_start = 1'b1;
    ly         = 8'd20;
    obj_tall   = 1'b0;
    model(20, 1'b0);
    @(negedge clk);
    scan_start = 1'b0;
    chk("restart_count", 32'(sprite_count), 32'd0);
    body();

    // Randomized scans with Y values clustered around the line.
    for (int r = 0; r < 8; r++) begin
      l = int'($urandom_range(0, 255));
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(0, 1) == 1) mem[i] = 8'(l + 16 - int'($urandom_range(0, 20)));
        else mem[i] = 8'($urandom);
      end
      start(l, 1'($urandom));
      body();
    end

    // Reset during the EVAL of a hitting entry.
    fill(8'd0);
    mem[0] = 8'd16;
    start(0, 1'b0);
    @(negedge clk);
    chk("eval_we", 32'(bus.store_we), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("rst_eval");
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_busy", 32'(scan_busy), 32'd0);
      chk("post_rst_rd", 32'(bus.oam_rd), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
